// File: rtl/neuron_seq_if.sv
// Handshake and data bundle between neuron_seq, the layer controller and the shared MAC.
// The slave modport is the sequencer's view; master is the surrounding system.
interface neuron_seq_if #(
    parameter int N_NEURONS = 4,
    parameter int N_INPUTS  = 16
) ();
    localparam int NB = $clog2(N_NEURONS);
    localparam int IB = $clog2(N_INPUTS);

    logic                 start_i;
    logic                 abort_i;
    logic                 busy_o;
    logic                 done_o;
    logic [NB-1:0]        neuron_idx_o;
    logic [IB-1:0]        inp_idx_o;
    logic [NB+IB-1:0]     w_addr_o;
    logic                 mac_req_o;
    logic [19:0]          prod_i;
    logic                 prod_valid_i;
    logic [7:0]           bias_i;
    logic [23:0]          res_o;
    logic                 res_valid_o;
    logic [NB-1:0]        res_idx_o;

    modport slave (
        input  start_i, abort_i, prod_i, prod_valid_i, bias_i,
        output busy_o, done_o, neuron_idx_o, inp_idx_o, w_addr_o, mac_req_o,
               res_o, res_valid_o, res_idx_o
    );

    modport master (
        output start_i, abort_i, prod_i, prod_valid_i, bias_i,
        input  busy_o, done_o, neuron_idx_o, inp_idx_o, w_addr_o, mac_req_o,
               res_o, res_valid_o, res_idx_o
    );
endinterface

// File: rtl/neuron_seq.sv
// Layer sequencer: walks every neuron through bias load plus N_INPUTS MAC requests,
// accumulating signed products into a 24-bit wrap-around sum and emitting one result per neuron.
module neuron_seq #(
    parameter int N_NEURONS = 4,
    parameter int N_INPUTS  = 16
) (
    input  logic          clk,
    input  logic          rst,
    neuron_seq_if.slave   bus
);
    localparam int NB = $clog2(N_NEURONS);
    localparam int IB = $clog2(N_INPUTS);

    localparam logic [NB-1:0] LAST_NEURON = NB'(N_NEURONS - 1);
    localparam logic [IB-1:0] LAST_INPUT  = IB'(N_INPUTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [NB-1:0]   neuron_q, neuron_d;
    logic [IB-1:0]   inp_q, inp_d;
    logic [23:0]     acc_q, acc_d;
    logic [23:0]     res_q, res_d;
    logic [NB-1:0]   res_idx_q, res_idx_d;
    logic            mac_req_q, mac_req_d;
    logic            done_q, done_d;
    logic            res_valid_q, res_valid_d;

    logic [23:0]     bias_ext;
    logic [23:0]     prod_ext;

    assign bias_ext = {{16{bus.bias_i[7]}}, bus.bias_i};
    assign prod_ext = {{4{bus.prod_i[19]}}, bus.prod_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            neuron_q    <= '0;
            inp_q       <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            res_idx_q   <= '0;
            mac_req_q   <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            neuron_q    <= neuron_d;
            inp_q       <= inp_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            res_idx_q   <= res_idx_d;
            mac_req_q   <= mac_req_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
        end
    end

    // The pulse outputs are decided one cycle ahead, so they are raised on the
    // transition into ISSUE / DONE / the cycle after STORE and come straight from flops.
    always_comb begin
        state_d     = state_q;
        neuron_d    = neuron_q;
        inp_d       = inp_q;
        acc_d       = acc_q;
        res_d       = res_q;
        res_idx_d   = res_idx_q;
        mac_req_d   = 1'b0;
        done_d      = 1'b0;
        res_valid_d = 1'b0;

        if (bus.abort_i) begin
            // Abort beats start and prod_valid; the accumulator is left as-is.
            state_d  = S_IDLE;
            neuron_d = '0;
            inp_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        state_d  = S_LOAD;
                        neuron_d = '0;
                        inp_d    = '0;
                    end
                end
                S_LOAD: begin
                    acc_d     = bias_ext;
                    inp_d     = '0;
                    state_d   = S_ISSUE;
                    mac_req_d = 1'b1;
                end
                S_ISSUE: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.prod_valid_i) begin
                        acc_d = acc_q + prod_ext;
                        if (inp_q == LAST_INPUT) begin
                            state_d = S_STORE;
                        end else begin
                            inp_d     = inp_q + 1'b1;
                            state_d   = S_ISSUE;
                            mac_req_d = 1'b1;
                        end
                    end
                end
                S_STORE: begin
                    res_d       = acc_q;
                    res_idx_d   = neuron_q;
                    res_valid_d = 1'b1;
                    if (neuron_q == LAST_NEURON) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        neuron_d = neuron_q + 1'b1;
                        state_d  = S_LOAD;
                    end
                end
                S_DONE: begin
                    state_d  = S_IDLE;
                    neuron_d = '0;
                    inp_d    = '0;
                end
                default: begin
                    state_d  = S_IDLE;
                    neuron_d = '0;
                    inp_d    = '0;
                end
            endcase
        end
    end

    assign bus.busy_o       = (state_q != S_IDLE);
    assign bus.done_o       = done_q;
    assign bus.mac_req_o    = mac_req_q;
    assign bus.res_valid_o  = res_valid_q;
    assign bus.res_o        = res_q;
    assign bus.res_idx_o    = res_idx_q;
    assign bus.neuron_idx_o = neuron_q;
    assign bus.inp_idx_o    = inp_q;
    assign bus.w_addr_o     = {neuron_q, inp_q};
endmodule
